// File: rtl/set_assoc_cache_if.sv
// Request/response bus for set_assoc_cache: valid/ready request in, one-cycle response pulse out.
interface set_assoc_cache_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [LINE_WIDTH-1:0] in_val;
    logic                  resp_valid;
    logic                  hit;
    logic [LINE_WIDTH-1:0] out_val;

    modport master (
        output req_valid, req_write, in_addr, in_val,
        input  req_ready, resp_valid, hit, out_val
    );

    modport slave (
        input  req_valid, req_write, in_addr, in_val,
        output req_ready, resp_valid, hit, out_val
    );
endinterface

// File: rtl/set_assoc_cache.sv
// SETS x WAYS set-associative cache array with per-set CLOCK (second-chance) replacement.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module set_assoc_cache #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned SETS       = 4,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    set_assoc_cache_if.slave      bus
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
`endif
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;
    localparam int unsigned WAY_W = $clog2(WAYS);

    if (SETS < 2 || (SETS & (SETS - 1)) != 0 || IDX_W >= ADDR_WIDTH) begin : g_chk_sets
        $error("SETS must be a power of two >= 2 and narrower than the address");
    end
    if (WAYS < 2) begin : g_chk_ways
        $error("WAYS must be >= 2");
    end
    if (STAT_WIDTH < 1) begin : g_chk_stat
        $error("STAT_WIDTH must be >= 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_EVICT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_valid [SETS][WAYS];
    logic                  r_ref   [SETS][WAYS];
    logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
    logic [LINE_WIDTH-1:0] r_data  [SETS][WAYS];
    logic [WAY_W-1:0]      r_ptr   [SETS];

    logic [IDX_W-1:0]      r_req_idx;
    logic [TAG_W-1:0]      r_req_tag;
    logic [LINE_WIDTH-1:0] r_req_val;

    logic                  r_resp_valid;
    logic                  r_hit;
    logic [LINE_WIDTH-1:0] r_out_val;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic                  w_free;
    logic [WAY_W-1:0]      w_free_way;
    logic [WAY_W-1:0]      w_ev_way;

    logic                  w_accept;
    logic                  w_resp;
    logic                  w_resp_hit;
    logic [LINE_WIDTH-1:0] w_resp_data;
    logic                  w_upd;
    logic [IDX_W-1:0]      w_upd_idx;
    logic [WAY_W-1:0]      w_upd_way;
    logic [TAG_W-1:0]      w_upd_tag;
    logic [LINE_WIDTH-1:0] w_upd_data;
    logic                  w_touch;
    logic                  w_clr;
    logic                  w_adv;

    assign w_idx    = bus.in_addr[IDX_W-1:0];
    assign w_tag    = bus.in_addr[ADDR_WIDTH-1:IDX_W];
    assign w_ev_way = r_ptr[r_req_idx];

    assign bus.resp_valid = r_resp_valid;
    assign bus.hit        = r_hit;
    assign bus.out_val    = r_out_val;

    // Scan downward so the lowest-index invalid way wins the fill.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_free     = 1'b0;
        w_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_free     = 1'b1;
                w_free_way = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = (r_state == ST_IDLE);
        w_accept      = 1'b0;
        w_resp        = 1'b0;
        w_resp_hit    = 1'b0;
        w_resp_data   = '0;
        w_upd         = 1'b0;
        w_upd_idx     = w_idx;
        w_upd_way     = w_hit_way;
        w_upd_tag     = w_tag;
        w_upd_data    = bus.in_val;
        w_touch       = 1'b0;
        w_clr         = 1'b0;
        w_adv         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (!bus.req_write) begin
                        w_resp     = 1'b1;
                        w_resp_hit = w_hit;
                        if (w_hit) begin
                            w_resp_data = r_data[w_idx][w_hit_way];
                            w_touch     = 1'b1;
                        end
                    end else if (w_hit) begin
                        w_upd      = 1'b1;
                        w_resp     = 1'b1;
                        w_resp_hit = 1'b1;
                    end else if (w_free) begin
                        w_upd     = 1'b1;
                        w_upd_way = w_free_way;
                        w_resp    = 1'b1;
                    end else begin
                        w_state_nxt = ST_EVICT;
                    end
                end
            end
            ST_EVICT: begin
                // Second chance: a set ref bit buys the line one more sweep.
                w_upd_idx  = r_req_idx;
                w_upd_way  = w_ev_way;
                w_upd_tag  = r_req_tag;
                w_upd_data = r_req_val;
                w_adv      = 1'b1;
                if (r_ref[r_req_idx][w_ev_way]) begin
                    w_clr = 1'b1;
                end else begin
                    w_upd       = 1'b1;
                    w_resp      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_ref[s][w]   <= 1'b0;
                end
                r_ptr[s] <= '0;
            end
            r_resp_valid <= 1'b0;
            r_hit        <= 1'b0;
            r_out_val    <= '0;
        end else begin
            r_resp_valid <= w_resp;
            if (w_resp) begin
                r_hit     <= w_resp_hit;
                r_out_val <= w_resp_data;
            end
            if (w_upd) begin
                r_valid[w_upd_idx][w_upd_way] <= 1'b1;
                r_ref[w_upd_idx][w_upd_way]   <= 1'b1;
            end
            if (w_touch) r_ref[w_idx][w_hit_way] <= 1'b1;
            if (w_clr)   r_ref[w_upd_idx][w_upd_way] <= 1'b0;
            if (w_adv) begin
                r_ptr[r_req_idx] <= (r_ptr[r_req_idx] == WAY_W'(WAYS - 1)) ? '0
                                    : r_ptr[r_req_idx] + 1'b1;
            end
        end
    end

    // Line contents and the latched request need no reset.
    always_ff @(posedge clock) begin
        if (w_upd) begin
            r_tag[w_upd_idx][w_upd_way]  <= w_upd_tag;
            r_data[w_upd_idx][w_upd_way] <= w_upd_data;
        end
        if (w_accept) begin
            r_req_idx <= w_idx;
            r_req_tag <= w_tag;
            r_req_val <= bus.in_val;
        end
    end

`ifdef CACHE_STATS_EN
    logic [STAT_WIDTH-1:0] r_hit_cnt;
    logic [STAT_WIDTH-1:0] r_miss_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_resp) begin
            if (w_resp_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + 1'b1;
            if (!w_resp_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif
endmodule
